// File: rtl/af4_ipoh_rrsch8_pkg.sv
// Shared constants for the 8-way rotating-priority grant scheduler.
// Latency: n/a (types and constants only); backpressure: n/a.
package af4_ipoh_rrsch8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GNT  = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/af4_ipoh_rrsch8_vote8.sv
// Combinational 8-way voter: first asserted req at or after prior, wrapping 7->0.
// Latency: 0 cycles; backpressure: none (pure function of its inputs).
module af4_ipoh_vote8
    import af4_ipoh_rrsch8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] prior,
    output logic [IDX_W-1:0] win,
    output logic             winval
);

    logic [IDX_W-1:0] idx;

    // Scan from farthest to nearest so the nearest hit to prior is written last.
    always_comb begin
        win    = '0;
        winval = 1'b0;
        idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = prior + IDX_W'(i);
            if (req[idx]) begin
                win    = idx;
                winval = 1'b1;
            end
        end
    end

endmodule

// File: rtl/af4_ipoh_rrsch8.sv
// Round-robin grant holder for 8 requesters; optional hold timeout via AF4_RRSCH_TIMEOUT_EN.
// Latency: req sampled at edge N is granted at edge N+1; no backpressure, req held until served.
module af4_ipoh_rrsch8
    import af4_ipoh_rrsch8_pkg::*;
#(
    parameter int HOLD_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gntid,
    output logic             gntval,
    output logic [IDX_W-1:0] prior,
    output logic             toerr
);

    if (HOLD_W < 1) begin : g_bad_hold_w
        $error("HOLD_W must be at least 1");
    end

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gntid_q, gntid_d;
    logic [IDX_W-1:0] prior_q, prior_d;

    logic [IDX_W-1:0] win;
    logic             winval;
    logic             rel_norm;
    logic             tout;

    af4_ipoh_vote8 u_vote (
        .req    (req),
        .prior  (prior_q),
        .win    (win),
        .winval (winval)
    );

    // A dropped request from the holder is treated exactly like done.
    assign rel_norm = done || !req[gntid_q];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gntid_d = gntid_q;
        prior_d = prior_q;
        case (state_q)
            ST_IDLE: begin
                if (en && winval) begin
                    state_d = ST_GNT;
                    gnt_d   = idx_to_onehot(win);
                    gntid_d = win;
                end
            end
            ST_GNT: begin
                if (rel_norm || tout) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    prior_d = gntid_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            gntid_q <= '0;
            prior_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gntid_q <= gntid_d;
            prior_q <= prior_d;
        end
    end

`ifdef AF4_RRSCH_TIMEOUT_EN
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [HOLD_W-1:0] cnt_inc;
    logic              toerr_q, toerr_d;

    // Counter is zero throughout IDLE, so it is already cleared on entry to GNT;
    // the release fires on the GNT cycle whose increment reaches all-ones.
    assign cnt_inc = cnt_q + HOLD_W'(1);
    assign tout    = (state_q == ST_GNT) && (&cnt_inc);

    always_comb begin
        cnt_d   = '0;
        toerr_d = 1'b0;
        if (state_q == ST_GNT) begin
            cnt_d   = rel_norm || tout ? '0 : cnt_inc;
            toerr_d = tout && !rel_norm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            toerr_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            toerr_q <= toerr_d;
        end
    end

    assign toerr = toerr_q;
`else
    assign tout  = 1'b0;
    assign toerr = 1'b0;
`endif

    assign gnt    = gnt_q;
    assign gntid  = gntid_q;
    assign gntval = (state_q == ST_GNT);
    assign prior  = prior_q;

endmodule

// File: doc/af4_ipoh_rrsch8.md
AF4_IPOH_RRSCH8 -- requirements
Module: af4_ipoh_rrsch8

Interface
REQ-001 Parameter HOLD_W, default 4: width of the grant hold counter; the hold limit is 2^HOLD_W-1 cycles.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  arbitration enable; when low, no new grant is issued and an existing grant is unaffected.
REQ-005 req  input  8  per-requester request, level, held until served.
REQ-006 done  input  1  single-cycle release pulse from the current grant holder.
REQ-007 gnt  output  8  one-hot grant, registered.
REQ-008 gntid  output  3  index of the granted requester; valid only while gntval=1.
REQ-009 gntval  output  1  a grant is held.
REQ-010 prior  output  3  current rotating-priority base, registered.
REQ-011 toerr  output  1  one-cycle pulse on forced release (AF4_RRSCH_TIMEOUT_EN only; otherwise tied 0).

Function
REQ-012 The FSM SHALL have exactly two states: IDLE (no grant) and GNT (grant held).
REQ-013 In IDLE with en=1 and |req=1, the block SHALL select the winner combinationally as the first asserted req at or after index prior, in ascending order with wrap 7->0.
REQ-014 It SHALL register that winner into gnt/gntid, set gntval=1 and enter GNT on the same edge, so a request sampled at edge N is granted at edge N+1.
REQ-015 In IDLE with en=0 or req=0, all outputs SHALL hold their values, with gnt=0 and gntval=0.
REQ-016 In GNT, the block SHALL release when done=1 or when req[gntid]=0; a dropped request counts as a release.
REQ-017 On release, the block SHALL clear gnt and gntval, set prior to gntid+1 modulo 8 (7 wraps to 0) and return to IDLE.
REQ-018 After a release there SHALL be exactly one IDLE cycle, so back-to-back grants are separated by one cycle.
REQ-019 A done pulse received while in IDLE SHALL be ignored.
REQ-020 Changes on req lines other than req[gntid] SHALL NOT affect a held grant.
REQ-021 When the release edge coincides with the deassertion of en, the block SHALL go to IDLE and issue no grant until en=1.
REQ-022 gnt SHALL be one-hot or zero in every cycle, and gnt[gntid] SHALL equal gntval.
REQ-023 prior SHALL change only on a release.

Reset
REQ-024 At a rising clk edge with rst=1: state=IDLE, gnt=0, gntid=0, gntval=0, prior=0, toerr=0 and the hold counter=0.
REQ-025 Reset SHALL override every other input, including done, a mid-grant condition or a coincident release; prior SHALL NOT advance on that edge.

Configuration
REQ-026 The macro AF4_RRSCH_TIMEOUT_EN SHALL enable the hold-limit timeout.
REQ-027 With AF4_RRSCH_TIMEOUT_EN defined, the hold counter SHALL be cleared on entry to GNT and incremented each GNT cycle.
REQ-028 With AF4_RRSCH_TIMEOUT_EN defined, when the counter reaches 2^HOLD_W-1 without a release, the block SHALL force a release per REQ-017 and pulse toerr for one cycle on the same edge.
REQ-029 With AF4_RRSCH_TIMEOUT_EN defined, done or a dropped request on the limit cycle SHALL win: the release is normal and toerr=0.
REQ-030 Without AF4_RRSCH_TIMEOUT_EN, no counter SHALL exist, toerr SHALL be constant 0, and a grant SHALL be held indefinitely.

Structure
REQ-031 The shared package SHALL hold the state encoding constants (IDLE=1'b0, GNT=1'b1), the requester count 8 and the index width 3.
REQ-032 The winner selection SHALL be done by one instance of the existing 8-way rotating-priority voter af4_ipoh_vote8, with ports req, prior, win and winval.
REQ-033 The block itself SHALL contain only the FSM, the registers and the counter.

Verification
REQ-034 Reset, then req=8'h81 with en=1: gnt=8'h01 and gntid=0 one cycle later; on done, prior=1; after one IDLE cycle, gnt=8'h80.
REQ-035 prior=6 and req=8'h22: gntid=1 (wrap 7->0 search); on release, prior=2.
REQ-036 Grant to 3, then drop req[3] with no done: gntval falls on the next edge and prior=4.
REQ-037 Hold grant 5 with done held low under AF4_RRSCH_TIMEOUT_EN and HOLD_W=4: forced release after 15 GNT cycles, a one-cycle toerr, and prior=6.
REQ-038 Repeat REQ-037 with done=1 on the limit cycle: normal release and toerr=0.
REQ-039 Assert rst=1 during a held grant to 2 with done=1 on the same edge: every output is 0 and prior=0, not 3.
